// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg
//   Shared types and constants for the pipeline sequencing controller.
//   ctrl_state_t    : controller FSM states (RUN, MEM_WAIT, HALT)
//   XZR             : register index hardwired to zero
//   DEFAULT_TIMEOUT : default number of MEM_WAIT cycles before halting
// ----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } ctrl_state_t;

    localparam logic [4:0]  XZR             = 5'd31;
    localparam int unsigned DEFAULT_TIMEOUT = 16;

    // Load-use check: a load in EX writes a register the ID instruction reads.
    // The zero register is never a real producer, so it never creates a hazard.
    function automatic logic load_use_hazard(
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rn,
        input logic [4:0] id_rm,
        input logic       id_uses_rm,
        input logic [4:0] zero_reg
    );
        return ex_mem_read && (ex_rd != zero_reg) &&
               ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter used for performance statistics.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low; clears count
//   inc   : increment request for this cycle
//   count : current value, holds at all-ones
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central sequencing controller for the IF/ID, ID/EX, EX/MEM, MEM/WB
//   pipeline registers and the PC. Handles load-use bubbles, taken-branch
//   flushes, data-memory freezes and a memory-timeout halt.
//
//   Inputs : clk, reset (async, active-low), id_rn, id_rm, id_uses_rm,
//            ex_rd, ex_mem_read, br_taken, mem_req, dmem_ready
//   Outputs: pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
//            memwb_en, memwb_bubble  (combinational from state + inputs)
//            mem_err (sticky), halted, stall_cnt, flush_cnt (saturating)
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W    = 32,
    parameter logic [4:0]  ZERO_REG = XZR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rm,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    ctrl_state_t   state;
    logic [WW-1:0] wait_cnt;
    logic          lu;
    logic          memstall;

    assign lu       = load_use_hazard(ex_mem_read, ex_rd, id_rn, id_rm,
                                      id_uses_rm, ZERO_REG);
    assign memstall = mem_req & ~dmem_ready;

    // ------------------------------------------------------------------
    // Pipeline-register controls. A MEM_WAIT cycle whose access completes
    // is resolved with the same priority as RUN (load-use over branch).
    // Everything is forced low while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;
        idex_en      = 1'b0;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b0;
        memwb_en     = 1'b0;
        memwb_bubble = 1'b0;
        halted       = 1'b0;

        if (reset) begin
            unique case (state)
                RUN, MEM_WAIT: begin
                    if ((state == RUN) ? memstall : !dmem_ready) begin
                        // Freeze upstream; WB takes a bubble so the retiring
                        // instruction is not written back twice.
                        memwb_en     = 1'b1;
                        memwb_bubble = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                        if (lu) begin
                            // The branch decision in ID may depend on the
                            // loaded value, so it is re-resolved next cycle.
                            pc_en       = 1'b0;
                            ifid_en     = 1'b0;
                            idex_bubble = 1'b1;
                        end else if (br_taken) begin
                            ifid_flush = 1'b1;
                        end
                    end
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, wait counter and sticky error.
    // wait_cnt counts stalled cycles including the RUN cycle that entered
    // MEM_WAIT, so HALT follows the TIMEOUT-th consecutive stalled cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (memstall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_ready) begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_LAST) begin
                            state   <= HALT;
                            mem_err <= 1'b1;
                        end
                    end else begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Performance counters. Reset clears them, so counting ~pc_en is safe
    // even though pc_en is also low while reset is asserted.
    // ------------------------------------------------------------------
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~pc_en),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ifid_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed bench for pipeline_hazard_ctrl (TIMEOUT=16, CNT_W=4).
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rn, id_rm, ex_rd;
    logic          id_uses_rm, ex_mem_read, br_taken, mem_req, dmem_ready;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
    logic          exmem_en, memwb_en, memwb_bubble, mem_err, halted;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
    //        exmem_en, memwb_en, memwb_bubble, mem_err, halted}
    logic [9:0] ctl;
    assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
                  exmem_en, memwb_en, memwb_bubble, mem_err, halted};

    localparam logic [9:0] C_ALL0 = 10'b0000000000;
    localparam logic [9:0] C_NORM = 10'b1101011000;
    localparam logic [9:0] C_LU   = 10'b0001111000;
    localparam logic [9:0] C_BR   = 10'b1111011000;
    localparam logic [9:0] C_FRZ  = 10'b0000001100;
    localparam logic [9:0] C_HALT = 10'b0000000011;

    pipeline_hazard_ctrl #(
        .TIMEOUT  (16),
        .CNT_W    (CW),
        .ZERO_REG (5'd31)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_uses_rm   (id_uses_rm),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .br_taken     (br_taken),
        .mem_req      (mem_req),
        .dmem_ready   (dmem_ready),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_bubble  (idex_bubble),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .memwb_bubble (memwb_bubble),
        .mem_err      (mem_err),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rn = 5'd0; id_rm = 5'd0; id_uses_rm = 1'b0; ex_rd = 5'd0;
        ex_mem_read = 1'b0; br_taken = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        // 1. reset held for two cycles
        idle();
        reset = 1'b0;
        tick();
        tick();
        chk("rst_ctl", 32'(ctl), 32'(C_ALL0));
        chk("rst_stall", 32'(stall_cnt), 0);
        chk("rst_flush", 32'(flush_cnt), 0);
        reset = 1'b1;
        #1;
        chk("run_ctl", 32'(ctl), 32'(C_NORM));
        tick();
        chk("run_stall", 32'(stall_cnt), 0);
        chk("run_flush", 32'(flush_cnt), 0);

        // 2. load-use on rn, then same pattern through XZR
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rn = 5'd5;
        #1;
        chk("lu_rn_ctl", 32'(ctl), 32'(C_LU));
        tick();
        chk("lu_rn_stall", 32'(stall_cnt), 1);
        ex_rd = 5'd31; id_rn = 5'd31;
        #1;
        chk("xzr_ctl", 32'(ctl), 32'(C_NORM));
        ex_rd = 5'd7; id_rn = 5'd1; id_rm = 5'd7; id_uses_rm = 1'b0;
        #1;
        chk("rm_unused_ctl", 32'(ctl), 32'(C_NORM));
        tick();
        chk("xzr_stall", 32'(stall_cnt), 1);

        // 3. load-use on rm masks a taken branch, then branch flushes
        ex_rd = 5'd3; id_rn = 5'd0; id_rm = 5'd3; id_uses_rm = 1'b1; br_taken = 1'b1;
        #1;
        chk("lu_br_ctl", 32'(ctl), 32'(C_LU));
        tick();
        chk("lu_br_flush", 32'(flush_cnt), 0);
        chk("lu_br_stall", 32'(stall_cnt), 2);
        ex_mem_read = 1'b0;
        #1;
        chk("br_ctl", 32'(ctl), 32'(C_BR));
        tick();
        chk("br_flush", 32'(flush_cnt), 1);
        chk("br_stall", 32'(stall_cnt), 2);

        // 4. three frozen cycles, then memory ready
        do_reset();
        mem_req = 1'b1; dmem_ready = 1'b0;
        #1;
        chk("frz1_ctl", 32'(ctl), 32'(C_FRZ));
        tick();
        chk("frz2_ctl", 32'(ctl), 32'(C_FRZ));
        tick();
        chk("frz3_ctl", 32'(ctl), 32'(C_FRZ));
        tick();
        dmem_ready = 1'b1;
        #1;
        chk("rdy_ctl", 32'(ctl), 32'(C_NORM));
        chk("rdy_stall", 32'(stall_cnt), 3);
        tick();
        mem_req = 1'b0; dmem_ready = 1'b0;
        #1;
        chk("back_run_ctl", 32'(ctl), 32'(C_NORM));
        tick();
        chk("back_run_stall", 32'(stall_cnt), 3);

        // 4b. ready cycle in MEM_WAIT obeys load-use priority
        mem_req = 1'b1; dmem_ready = 1'b0;
        tick();
        dmem_ready = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9; id_rn = 5'd9; br_taken = 1'b1;
        #1;
        chk("wait_rdy_lu_ctl", 32'(ctl), 32'(C_LU));
        tick();
        idle();

        // 5. timeout into HALT
        do_reset();
        mem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("to_frz%0d", i), 32'(ctl), 32'(C_FRZ));
            tick();
        end
        chk("halt_ctl", 32'(ctl), 32'(C_HALT));
        dmem_ready = 1'b1;
        #1;
        chk("halt_rdy_ctl", 32'(ctl), 32'(C_HALT));
        tick();
        chk("halt_hold_ctl", 32'(ctl), 32'(C_HALT));
        chk("halt_stall_sat", 32'(stall_cnt), 15);
        reset = 1'b0;
        #1;
        chk("halt_async_rst_ctl", 32'(ctl), 32'(C_ALL0));
        chk("halt_async_rst_cnt", 32'(stall_cnt), 0);
        idle();
        reset = 1'b1;
        #1;
        chk("halt_exit_ctl", 32'(ctl), 32'(C_NORM));

        // 6. stall counter saturation via 20 load-use cycles
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd4; id_rn = 5'd4;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", 32'(stall_cnt), 14);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_20", 32'(stall_cnt), 15);
        chk("sat_flush", 32'(flush_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
